// File: rtl/wb_initiator_if.sv
// Command/response streams plus the Wishbone classic master bus of wb_initiator.
// The master modport is the initiator's view; slave is the view of whoever
// drives commands, consumes responses and answers bus cycles.
interface wb_initiator_if;
  // Command stream
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  // Response stream
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  // Wishbone master bus
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  // Status
  logic        busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, busy
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic-cycle master. Turns one accepted command
// into one bus cycle, enforces an idle gap afterwards, and returns read data or
// a timeout error on a held response stream.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255,  // 1..65535 cycles without ack before abort
  parameter int unsigned GAP     = 1     // >= 1 idle cycles after every bus cycle
) (
  input logic            wb_clk_i,
  input logic            wb_rst_n_i,
  wb_initiator_if.master bus
);

  localparam int unsigned      GapW    = $clog2(GAP + 1);
  localparam logic [15:0]      ToLast  = 16'(TIMEOUT - 1);
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StBus, StGapW, StResp} state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [GapW-1:0] gcnt_q, gcnt_d;
  logic            cmd_ready;

  // A new command is only taken once the previous response has been consumed.
  assign cmd_ready = (state_q == StIdle) && !rsp_valid_q;

  // Next-state and next-output logic for the cycle sequencer.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;
    gcnt_d      = gcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready) begin
          we_d    = bus.cmd_we;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          sel_d   = bus.cmd_sel;
          cyc_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // ack is checked first so it wins over a coincident timeout
        if (bus.wbm_ack_i) begin
          rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
          gcnt_d    = '0;
          state_d   = StGapW;
        end else if (tcnt_q == ToLast) begin
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          gcnt_d    = '0;
          state_d   = StGapW;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StGapW: begin
        // Late acks land here and are deliberately not looked at.
        if (gcnt_q == GapLast) begin
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      sel_q       <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
      gcnt_q      <= gcnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: main instance with TIMEOUT=8, a second one
// with TIMEOUT=4 for the ack/timeout coincidence case.
module tb_wb_initiator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_initiator_if bif ();
  wb_initiator_if b2 ();

  wb_initiator #(.TIMEOUT(8), .GAP(1)) dut (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bif));
  wb_initiator #(.TIMEOUT(4), .GAP(1)) dut2 (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b2));

  int n_chk  = 0;
  int n_fail = 0;

  // Slave model: ack lands in the third cycle of cyc, one cycle wide.
  logic        slv_en, slv_xor, slv_ack, man_ack, man_ack2;
  logic [31:0] slv_dat;
  int          slv_cnt;

  // Registered ack generator for the main instance.
  always @(posedge clk) begin
    if (!slv_en || !bif.wbm_cyc_o) begin
      slv_cnt <= 0;
      slv_ack <= 1'b0;
    end else begin
      slv_cnt <= slv_cnt + 1;
      slv_ack <= (slv_cnt == 1);
    end
  end

  assign bif.wbm_ack_i = slv_ack | man_ack;
  assign bif.wbm_dat_i = !bif.wbm_ack_i ? 32'hDEAD_BEEF :
                         (slv_xor ? (bif.wbm_adr_o ^ 32'hA5A5_0000) : slv_dat);
  assign b2.wbm_ack_i  = man_ack2;
  assign b2.wbm_dat_i  = man_ack2 ? 32'h5A5A_A5A5 : 32'hDEAD_BEEF;

  logic        e_we;
  logic [31:0] e_adr, e_dat;
  logic [3:0]  e_sel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until the handshake edge has passed.
  task automatic issue(output bit ok);
    ok = 1'b0;
    bif.cmd_we    = e_we;
    bif.cmd_adr   = e_adr;
    bif.cmd_dat   = e_dat;
    bif.cmd_sel   = e_sel;
    bif.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bif.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bif.cmd_valid = 1'b0;
  endtask

  // Measure cyc length and the low cycles before rsp_valid; optionally ack late in the gap.
  task automatic watch(input bit late, output int hi, output int lo, output bit bad,
                       output bit got);
    hi = 0; lo = 0; bad = 1'b0; got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      man_ack = 1'b0;
      if (bif.rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (bif.wbm_stb_o !== bif.wbm_cyc_o || bif.busy !== 1'b1) bad = 1'b1;
      if (bif.wbm_cyc_o) begin
        hi++;
        if (bif.wbm_adr_o !== e_adr || bif.wbm_dat_o !== e_dat || bif.wbm_sel_o !== e_sel ||
            bif.wbm_we_o !== e_we) bad = 1'b1;
      end else if (hi > 0) begin
        lo++;
        if (late) man_ack = 1'b1;
      end
      tick();
    end
    man_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (bif.wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_cyc got %b exp 0", bif.wbm_cyc_o); end
    n_chk++; if (bif.wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_stb got %b exp 0", bif.wbm_stb_o); end
    n_chk++; if (bif.wbm_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", bif.wbm_we_o); end
    n_chk++; if (bif.wbm_adr_o !== 32'h0) begin n_fail++; $display("FAIL rst_adr got %h exp 0", bif.wbm_adr_o); end
    n_chk++; if (bif.wbm_sel_o !== 4'h0) begin n_fail++; $display("FAIL rst_sel got %h exp 0", bif.wbm_sel_o); end
    n_chk++; if (bif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 0", bif.rsp_valid); end
    n_chk++; if (bif.rsp_dat !== 32'h0 || bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp got %h/%b exp 0/0", bif.rsp_dat, bif.rsp_err); end
    n_chk++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bif.busy); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (bif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 1", bif.cmd_ready); end
  endtask

  task automatic test_write();
    int hi, lo; bit bad, got, ok;
    slv_en = 1'b1; slv_xor = 1'b0; bif.rsp_ready = 1'b0;
    e_we = 1'b1; e_adr = 32'h0080_0000; e_dat = 32'h0000_0011; e_sel = 4'hF;
    issue(ok);
    watch(1'b0, hi, lo, bad, got);
    n_chk++; if (ok !== 1'b1 || got !== 1'b1) begin n_fail++; $display("FAIL wr_handshake got %b/%b exp 1/1", ok, got); end
    n_chk++; if (hi !== 3) begin n_fail++; $display("FAIL wr_cyc_len got %0d exp 3", hi); end
    n_chk++; if (lo !== 1) begin n_fail++; $display("FAIL wr_gap_len got %0d exp 1", lo); end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL wr_bus_stable got %b exp 0", bad); end
    n_chk++; if (bif.rsp_err !== 1'b0 || bif.rsp_dat !== 32'h0) begin n_fail++; $display("FAIL wr_rsp got %h/%b exp 0/0", bif.rsp_dat, bif.rsp_err); end
    n_chk++; if (bif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_in_resp got %b exp 0", bif.cmd_ready); end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    n_chk++; if (bif.rsp_valid !== 1'b0 || bif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_after_hs got valid %b ready %b exp 0 1", bif.rsp_valid, bif.cmd_ready); end
  endtask

  task automatic test_read();
    int hi, lo, held; bit bad, got, ok;
    slv_en = 1'b1; slv_xor = 1'b0; slv_dat = 32'h1234_5678; bif.rsp_ready = 1'b0;
    e_we = 1'b0; e_adr = 32'h0040_0000; e_dat = 32'h0; e_sel = 4'hF;
    issue(ok);
    watch(1'b0, hi, lo, bad, got);
    n_chk++; if (got !== 1'b1 || hi !== 3) begin n_fail++; $display("FAIL rd_cycle got rsp %b len %0d exp 1 3", got, hi); end
    n_chk++; if (bif.rsp_dat !== 32'h1234_5678 || bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got %h/%b exp 12345678/0", bif.rsp_dat, bif.rsp_err); end
    held = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.rsp_valid === 1'b1 && bif.rsp_dat === 32'h1234_5678 && bif.rsp_err === 1'b0) held++;
    end
    n_chk++; if (held !== 4) begin n_fail++; $display("FAIL rd_hold got %0d exp 4", held); end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    n_chk++; if (bif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_clear got %b exp 0", bif.rsp_valid); end
  endtask

  task automatic test_timeout();
    int hi, lo; bit bad, got, ok;
    slv_en = 1'b0; bif.rsp_ready = 1'b0;
    e_we = 1'b0; e_adr = 32'h0000_0100; e_dat = 32'h0; e_sel = 4'hF;
    issue(ok);
    watch(1'b1, hi, lo, bad, got);
    n_chk++; if (got !== 1'b1 || hi !== 8) begin n_fail++; $display("FAIL to_cyc_len got rsp %b len %0d exp 1 8", got, hi); end
    n_chk++; if (bif.rsp_err !== 1'b1 || bif.rsp_dat !== 32'h0) begin n_fail++; $display("FAIL to_rsp got %h/%b exp 0/1", bif.rsp_dat, bif.rsp_err); end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    slv_en = 1'b1; slv_dat = 32'hCAFE_F00D;
    e_we = 1'b0; e_adr = 32'h0040_0004; e_sel = 4'h3;
    issue(ok);
    watch(1'b0, hi, lo, bad, got);
    n_chk++; if (got !== 1'b1 || hi !== 3 || bad !== 1'b0) begin n_fail++; $display("FAIL to_next_cycle got rsp %b len %0d bad %b exp 1 3 0", got, hi, bad); end
    n_chk++; if (bif.rsp_dat !== 32'hCAFE_F00D || bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL to_next_rsp got %h/%b exp cafef00d/0", bif.rsp_dat, bif.rsp_err); end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [3];
    logic [31:0] rsps [3];
    int idx, nrsp, n_hs, ready_cyc, pulses, low_run, min_gap;
    bit prev_cyc, hs_now;
    adrs = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
    slv_en = 1'b1; slv_xor = 1'b1; bif.rsp_ready = 1'b1;
    idx = 0; nrsp = 0; n_hs = 0; ready_cyc = 0; pulses = 0; low_run = 0; min_gap = 1000;
    prev_cyc = 1'b0;
    bif.cmd_we = 1'b0; bif.cmd_adr = adrs[0]; bif.cmd_dat = 32'h0; bif.cmd_sel = 4'hF;
    bif.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && nrsp < 3; i++) begin
      hs_now = bif.cmd_valid && bif.cmd_ready;
      if (bif.cmd_ready) ready_cyc++;
      if (bif.wbm_cyc_o && !prev_cyc) begin
        pulses++;
        if (pulses > 1 && low_run < min_gap) min_gap = low_run;
      end
      if (bif.wbm_cyc_o) low_run = 0; else low_run++;
      prev_cyc = bif.wbm_cyc_o;
      if (bif.rsp_valid && bif.rsp_ready) begin
        rsps[nrsp] = bif.rsp_dat;
        nrsp++;
      end
      tick();
      if (hs_now) begin
        n_hs++;
        idx++;
        if (idx < 3) bif.cmd_adr = adrs[idx];
        else bif.cmd_valid = 1'b0;
      end
    end
    bif.cmd_valid = 1'b0;
    bif.rsp_ready = 1'b0;
    n_chk++; if (nrsp !== 3 || n_hs !== 3) begin n_fail++; $display("FAIL b2b_count got rsp %0d hs %0d exp 3 3", nrsp, n_hs); end
    n_chk++; if (ready_cyc !== 3) begin n_fail++; $display("FAIL b2b_ready_pulses got %0d exp 3", ready_cyc); end
    n_chk++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_cyc_pulses got %0d exp 3", pulses); end
    n_chk++; if (min_gap !== 3) begin n_fail++; $display("FAIL b2b_min_gap got %0d exp 3", min_gap); end
    n_chk++; if (rsps[0] !== 32'hA5A5_0010) begin n_fail++; $display("FAIL b2b_rsp0 got %h exp a5a50010", rsps[0]); end
    n_chk++; if (rsps[1] !== 32'hA5A5_0020) begin n_fail++; $display("FAIL b2b_rsp1 got %h exp a5a50020", rsps[1]); end
    n_chk++; if (rsps[2] !== 32'hA5A5_0030) begin n_fail++; $display("FAIL b2b_rsp2 got %h exp a5a50030", rsps[2]); end
  endtask

  task automatic test_reset_mid_bus();
    int hi, lo; bit bad, got, ok;
    slv_en = 1'b0; slv_xor = 1'b0; bif.rsp_ready = 1'b0;
    e_we = 1'b0; e_adr = 32'h0040_0010; e_dat = 32'h0; e_sel = 4'hF;
    issue(ok);
    tick();
    n_chk++; if (bif.wbm_cyc_o !== 1'b1) begin n_fail++; $display("FAIL mid_in_bus got cyc %b exp 1", bif.wbm_cyc_o); end
    rst_n = 1'b0;
    tick();
    n_chk++; if (bif.wbm_cyc_o !== 1'b0 || bif.wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bus got %b%b exp 00", bif.wbm_cyc_o, bif.wbm_stb_o); end
    n_chk++; if (bif.rsp_valid !== 1'b0 || bif.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state got valid %b busy %b exp 0 0", bif.rsp_valid, bif.busy); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (bif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready got %b exp 1", bif.cmd_ready); end
    slv_en = 1'b1; slv_dat = 32'h0BAD_F00D;
    issue(ok);
    watch(1'b0, hi, lo, bad, got);
    n_chk++; if (got !== 1'b1 || bif.rsp_dat !== 32'h0BAD_F00D || bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL mid_fresh_read got %b %h/%b exp 1 0badf00d/0", got, bif.rsp_dat, bif.rsp_err); end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_ack_timeout_coincide();
    b2.cmd_we = 1'b0; b2.cmd_adr = 32'h0040_0008; b2.cmd_dat = 32'h0; b2.cmd_sel = 4'hF;
    b2.rsp_ready = 1'b0;
    n_chk++; if (b2.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL co_ready got %b exp 1", b2.cmd_ready); end
    b2.cmd_valid = 1'b1;
    tick();
    b2.cmd_valid = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (b2.wbm_cyc_o !== 1'b1) begin n_fail++; $display("FAIL co_cyc4 got %b exp 1", b2.wbm_cyc_o); end
    man_ack2 = 1'b1;
    tick();
    man_ack2 = 1'b0;
    n_chk++; if (b2.wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL co_cyc_drop got %b exp 0", b2.wbm_cyc_o); end
    tick();
    n_chk++; if (b2.rsp_valid !== 1'b1 || b2.rsp_err !== 1'b0) begin n_fail++; $display("FAIL co_rsp got valid %b err %b exp 1 0", b2.rsp_valid, b2.rsp_err); end
    n_chk++; if (b2.rsp_dat !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL co_dat got %h exp 5a5aa5a5", b2.rsp_dat); end
    b2.rsp_ready = 1'b1;
    tick();
    b2.rsp_ready = 1'b0;
  endtask

  initial begin
    slv_en = 1'b0; slv_xor = 1'b0; slv_dat = 32'h0; man_ack = 1'b0; man_ack2 = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd_we = 1'b0; bif.cmd_adr = 32'h0; bif.cmd_dat = 32'h0;
    bif.cmd_sel = 4'h0; bif.rsp_ready = 1'b0;
    b2.cmd_valid = 1'b0; b2.cmd_we = 1'b0; b2.cmd_adr = 32'h0; b2.cmd_dat = 32'h0;
    b2.cmd_sel = 4'h0; b2.rsp_ready = 1'b0;
    e_we = 1'b0; e_adr = 32'h0; e_dat = 32'h0; e_sel = 4'h0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    test_ack_timeout_coincide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Single-outstanding Wishbone classic-cycle master.
- Converts a valid/ready command stream into bus cycles on the wbs_* slave port of the design multiplexer, so on-chip logic (test sequencers, boot loaders) can reach the mux registers and the 64x8 SRAM window without the management core.
- Returns read data, or a timeout error, on a buffered valid/ready response stream.

Parameters:
- TIMEOUT, 255: cycles with cyc/stb asserted and no ack before the cycle is aborted with rsp_err=1. Range 1..65535.
- GAP, 1: idle cycles with cyc/stb low, enforced after every completed or aborted cycle. Minimum 1. Covers the slave's registered ack/feedback delay.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_n_i  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_dat  out  32  read data; 0 for writes and timeouts
- rsp_err  out  1  1 = cycle timed out
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe; always equal to wbm_cyc_o
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (wb_rst_n_i=0 at clock edge):
  - state=IDLE.
  - All outputs 0: cyc, stb, we, adr, dat, sel, rsp_valid, rsp_dat, rsp_err, busy.
  - Timeout and gap counters = 0.
  - Reset mid-cycle drops cyc/stb on the next edge. Any pending response is discarded.
- States: IDLE, BUS, GAP_W, RESP.
- cmd_ready = (state==IDLE) & !rsp_valid. Combinational; does not depend on cmd_valid.
- IDLE:
  - On cmd_valid & cmd_ready, register we/adr/dat/sel onto wbm_* and set cyc=stb=1.
  - Timeout counter := 0. Go to BUS.
  - First bus cycle starts 1 clock after acceptance.
  - wbm_adr/dat/sel/we stay stable until the next accepted command.
- BUS:
  - Each cycle with ack=0, counter+1.
  - ack=1: capture rsp_dat = we ? 0 : wbm_dat_i, rsp_err=0.
  - Otherwise, when counter reaches TIMEOUT-1 with ack=0: rsp_dat=0, rsp_err=1.
  - On either exit, cyc=stb=0 at the next edge and go to GAP_W.
  - ack in the same cycle as the timeout limit counts as success; ack wins.
  - Minimum length: 1 cycle, for a zero-wait slave.
- GAP_W:
  - cyc=stb=0 for GAP cycles. ack arriving here is ignored.
  - Then go to RESP with rsp_valid=1.
- RESP:
  - rsp_valid held with rsp_dat/rsp_err stable until rsp_ready.
  - On handshake, rsp_valid=0 and go to IDLE. cmd_ready rises the following cycle.
  - The first response is never lost or overwritten.
- Latency against the multiplexer slave (ack 2 cycles after stb), GAP=1, rsp_ready tied 1:
  - Accept at T; cyc at T+1; ack seen at T+3; cyc low at T+4; rsp_valid at T+5; cmd_ready at T+6.
- Counters:
  - Timeout counter is 16 bits; compare uses TIMEOUT-1, with no wrap.
  - Gap counter is ceil(log2(GAP+1)) bits.
- busy = (state != IDLE).

Test Plan:
- Write with ack 2 cycles after stb: cmd we=1, adr=0x0080_0000, dat=0x0000_0011. Required:
  - wbm_adr/dat/sel (sel=4'hF) held for the whole cycle.
  - cyc high exactly 3 cycles, then low 1 cycle.
  - rsp_valid with rsp_err=0, rsp_dat=0.
- Read: cmd we=0, adr=0x0040_0000; slave returns 0x1234_5678 with ack. Required:
  - rsp_dat=0x1234_5678, rsp_err=0.
  - Response held 4 cycles while rsp_ready=0, then cleared 1 cycle after rsp_ready=1.
- Timeout with TIMEOUT=8 and ack never asserted. Required:
  - cyc high exactly 8 cycles.
  - rsp_err=1, rsp_dat=0.
  - A late ack during GAP_W is ignored, and the next command still completes normally.
- Back-to-back: cmd_valid held with 3 queued commands and rsp_ready=1. Required:
  - cmd_ready pulses once per transaction.
  - At least GAP idle cycles between cyc pulses.
  - Responses arrive in order.
- Reset mid-BUS: wb_rst_n_i=0 in the 2nd BUS cycle. Required:
  - cyc/stb/rsp_valid/busy = 0 on the next edge.
  - After release, cmd_ready=1 and a fresh read returns correct data.
- Ack/timeout coincidence with TIMEOUT=4: ack on the 4th BUS cycle. Required: rsp_err=0 and rsp_dat is the captured data.
